// File: rtl/key_conditioner_if.sv
// Key pin and conditioned-event bundle between the raw push-button pins and the clock control logic.
// The conditioner is the slave: it reads the pins and drives the conditioned levels and pulses.
interface key_conditioner_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_down;
    logic [N_KEYS-1:0] key_up;
    logic [N_KEYS-1:0] key_rep;
    logic [N_KEYS-1:0] key_long;

    modport master (
        output key_raw,
        input  key_level, key_down, key_up, key_rep, key_long
    );

    modport slave (
        input  key_raw,
        output key_level, key_down, key_up, key_rep, key_long
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop sync, debounce, press/release pulses, long press and auto-repeat.
//   state   | meaning
//   IDLE    | key released (debounced level 0)
//   PRESSED | key held, counting towards long press
//   REPEAT  | long press reached, emitting periodic repeat pulses
module key_conditioner #(
    parameter int N_KEYS            = 2,
    parameter int KEY_ACTIVE_HIGH   = 1,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int LONG_PRESS_CYCLES = 32768,
    parameter int REPEAT_CYCLES     = 8192
) (
    input  logic             clock,
    input  logic             reset,
    key_conditioner_if.slave keys
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] sync_1;
    logic [N_KEYS-1:0] sync_2;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] down;
    logic [N_KEYS-1:0] up;
    logic [N_KEYS-1:0] rep;
    logic [N_KEYS-1:0] long_press;

    logic [DB_W-1:0]   db_cnt   [N_KEYS];
    logic [HOLD_W-1:0] hold_cnt [N_KEYS];
    logic [REP_W-1:0]  rep_cnt  [N_KEYS];
    state_t            state    [N_KEYS];

    // Normalise to pressed = 1 ahead of the first synchroniser flop.
    assign pressed = (KEY_ACTIVE_HIGH != 0) ? keys.key_raw : ~keys.key_raw;

    // The cycle whose increment would reach DEBOUNCE_CYCLES is the accept cycle.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            accept[i] = (sync_2[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1     <= '0;
            sync_2     <= '0;
            level      <= '0;
            down       <= '0;
            up         <= '0;
            rep        <= '0;
            long_press <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
                rep_cnt[i]  <= '0;
                state[i]    <= IDLE;
            end
        end else begin
            sync_1     <= pressed;
            sync_2     <= sync_1;
            down       <= '0;
            up         <= '0;
            rep        <= '0;
            long_press <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync_2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    db_cnt[i] <= '0;
                    level[i]  <= ~level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end

                // A release accepted on a tick cycle takes priority over the tick.
                case (state[i])
                    IDLE: begin
                        if (accept[i] && !level[i]) begin
                            state[i]    <= PRESSED;
                            down[i]     <= 1'b1;
                            rep[i]      <= 1'b1;
                            hold_cnt[i] <= '0;
                        end
                    end
                    PRESSED: begin
                        if (accept[i] && level[i]) begin
                            state[i] <= IDLE;
                            up[i]    <= 1'b1;
                        end else if (hold_cnt[i] == HOLD_LAST) begin
                            state[i]      <= REPEAT;
                            long_press[i] <= 1'b1;
                            rep[i]        <= 1'b1;
                            hold_cnt[i]   <= '0;
                            rep_cnt[i]    <= '0;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (accept[i] && level[i]) begin
                            state[i]   <= IDLE;
                            up[i]      <= 1'b1;
                            rep_cnt[i] <= '0;
                        end else if (rep_cnt[i] == REP_LAST) begin
                            rep[i]     <= 1'b1;
                            rep_cnt[i] <= '0;
                        end else begin
                            rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign keys.key_level = level;
    assign keys.key_down  = down;
    assign keys.key_up    = up;
    assign keys.key_rep   = rep;
    assign keys.key_long  = long_press;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: an active-high and an active-low instance fed complementary pins,
// both compared every cycle to an event-timing model, plus a timeline table and corner sequences.
module tb_key_conditioner;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw = 2'b00;
    logic       chk_en = 1'b0;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    key_conditioner_if #(.N_KEYS(2)) ifa ();
    key_conditioner_if #(.N_KEYS(2)) ifb ();
    assign ifa.key_raw = raw;
    assign ifb.key_raw = ~raw;

    key_conditioner #(.N_KEYS(2), .KEY_ACTIVE_HIGH(1), .DEBOUNCE_CYCLES(D),
                      .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R))
        dut_a (.clock(clk), .reset(rst_n), .keys(ifa));

    key_conditioner #(.N_KEYS(2), .KEY_ACTIVE_HIGH(0), .DEBOUNCE_CYCLES(D),
                      .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R))
        dut_b (.clock(clk), .reset(rst_n), .keys(ifb));

    function automatic logic [9:0] outs_a();
        return {ifa.key_level, ifa.key_down, ifa.key_up, ifa.key_rep, ifa.key_long};
    endfunction

    function automatic logic [9:0] outs_b();
        return {ifb.key_level, ifb.key_down, ifb.key_up, ifb.key_rep, ifb.key_long};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %b expected %b (lvl/dn/up/rep/long) at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pin seen two samples late; a level change is accepted after D consecutive
    // disagreeing samples; pulses follow from the time elapsed since the accepted press.
    logic [1:0] m_s1, m_s2, m_level;
    logic [1:0] e_down, e_up, e_rep, e_long;
    int         m_run [2];
    int         m_held [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0;
            e_down = 0; e_up = 0; e_rep = 0; e_long = 0;
            for (int k = 0; k < 2; k++) begin m_run[k] = 0; m_held[k] = -1; end
        end else begin
            e_down = 0; e_up = 0; e_rep = 0; e_long = 0;
            for (int k = 0; k < 2; k++) begin
                if (m_s2[k] != m_level[k] && m_run[k] == D - 1) begin
                    m_level[k] = ~m_level[k];
                    m_run[k] = 0;
                    if (m_level[k]) begin
                        e_down[k] = 1; e_rep[k] = 1; m_held[k] = 0;
                    end else begin
                        e_up[k] = 1; m_held[k] = -1;
                    end
                end else begin
                    m_run[k] = (m_s2[k] != m_level[k]) ? m_run[k] + 1 : 0;
                    if (m_held[k] >= 0) begin
                        m_held[k]++;
                        if (m_held[k] == L) begin
                            e_long[k] = 1; e_rep[k] = 1;
                        end else if (m_held[k] > L && (m_held[k] - L) % R == 0) begin
                            e_rep[k] = 1;
                        end
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    logic [9:0] log_a [128];
    logic [9:0] log_b [128];

    always @(negedge clk) begin
        if (cyc < 128) begin
            log_a[cyc] = outs_a();
            log_b[cyc] = outs_b();
        end
        if (chk_en) begin
            check("model_a", outs_a(), {m_level, e_down, e_up, e_rep, e_long});
            check("model_b", outs_b(), {m_level, e_down, e_up, e_rep, e_long});
        end
    end

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) check_int("wait_timeout", cyc, n);
    endtask

    function automatic int pick_dur();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(1, 3);
            1:       return $urandom_range(4, 10);
            2:       return $urandom_range(15, 40);
            default: return $urandom_range(40, 70);
        endcase
    endfunction

    typedef struct {
        int   edge_n;
        logic lvl, dn, up, rp, lg;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int t0, cnt_rep, cnt_up, seen;
        int dur [2];

        // Key 0 pressed first sampled at edge 10, release first sampled at edge 55.
        tbl[0]  = '{14, 0, 0, 0, 0, 0};
        tbl[1]  = '{15, 1, 1, 0, 1, 0};
        tbl[2]  = '{16, 1, 0, 0, 0, 0};
        tbl[3]  = '{34, 1, 0, 0, 0, 0};
        tbl[4]  = '{35, 1, 0, 0, 1, 1};
        tbl[5]  = '{36, 1, 0, 0, 0, 0};
        tbl[6]  = '{39, 1, 0, 0, 0, 0};
        tbl[7]  = '{40, 1, 0, 0, 1, 0};
        tbl[8]  = '{45, 1, 0, 0, 1, 0};
        tbl[9]  = '{50, 1, 0, 0, 1, 0};
        tbl[10] = '{55, 1, 0, 0, 1, 0};
        tbl[11] = '{59, 1, 0, 0, 0, 0};
        tbl[12] = '{60, 0, 0, 1, 0, 0};
        tbl[13] = '{61, 0, 0, 0, 0, 0};

        // Reset state (active-low instance sees all-ones pins here).
        raw = 2'b00;
        do_reset();
        @(negedge clk);
        check("reset_a", outs_a(), 10'b0);
        check("reset_b", outs_b(), 10'b0);

        // Clean press, long press, repeats, release coinciding with a repeat tick.
        wait_cyc(9);
        raw[0] = 1'b1;
        wait_cyc(54);
        raw[0] = 1'b0;
        wait_cyc(64);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("tbl_a_e%0d", tbl[i].edge_n), log_a[tbl[i].edge_n],
                  {1'b0, tbl[i].lvl, 1'b0, tbl[i].dn, 1'b0, tbl[i].up, 1'b0, tbl[i].rp, 1'b0, tbl[i].lg});
            check($sformatf("tbl_b_e%0d", tbl[i].edge_n), log_b[tbl[i].edge_n],
                  {1'b0, tbl[i].lvl, 1'b0, tbl[i].dn, 1'b0, tbl[i].up, 1'b0, tbl[i].rp, 1'b0, tbl[i].lg});
        end

        // Bounce of 3 cycles is rejected, and the counter restarts from zero afterwards.
        raw[0] = 1'b1;
        repeat (3) @(negedge clk);
        raw[0] = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(ifa.key_level[0] | ifa.key_down[0] | ifa.key_rep[0] | ifb.key_level[0]);
        end
        check_int("bounce_no_event", seen, 0);
        t0 = cyc;
        raw[0] = 1'b1;
        wait_cyc(t0 + 5);
        check_int("post_bounce_early", int'(ifa.key_level[0]), 0);
        wait_cyc(t0 + 6);
        check_int("post_bounce_down", int'(ifa.key_down[0]), 1);
        raw[0] = 1'b0;
        wait_cyc(t0 + 20);

        // Both keys together; releasing key 1 leaves key 0 repeating.
        t0 = cyc;
        raw = 2'b11;
        wait_cyc(t0 + 6);
        check_int("both_down_a", int'(ifa.key_down), 3);
        check_int("both_down_b", int'(ifb.key_down), 3);
        wait_cyc(t0 + 10);
        raw[1] = 1'b0;
        cnt_rep = 0;
        cnt_up = 0;
        for (int c = t0 + 11; c <= t0 + 46; c++) begin
            wait_cyc(c);
            cnt_up += int'(ifa.key_up[1]);
            if (c >= t0 + 17) cnt_rep += int'(ifa.key_rep[0]);
        end
        check_int("key1_single_up", cnt_up, 1);
        check_int("key0_keeps_repeating", cnt_rep, 5);
        raw = 2'b00;
        wait_cyc(t0 + 60);

        // Reset asserted mid-hold: asynchronous clear, then re-detection as a new press.
        do_reset();
        wait_cyc(9);
        raw[0] = 1'b1;
        wait_cyc(37);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", outs_a(), 10'b0);
        check("async_reset_b", outs_b(), 10'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_up = 0;
        for (int c = 1; c <= 20; c++) begin
            wait_cyc(c);
            cnt_up += int'(ifa.key_up[0]) + int'(ifb.key_up[0]);
            if (c == 5) check_int("rearm_not_yet", int'(ifa.key_down[0]) + int'(ifa.key_level[0]), 0);
            if (c == 6) check_int("rearm_down_a", int'(ifa.key_down[0]), 1);
            if (c == 6) check_int("rearm_down_b", int'(ifb.key_down[0]), 1);
        end
        check_int("rearm_no_up", cnt_up, 0);
        raw = 2'b00;
        repeat (10) @(negedge clk);

        // Randomised pin activity, checked every cycle by the model.
        dur[0] = 1;
        dur[1] = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                dur[k]--;
                if (dur[k] == 0) begin
                    raw[k] = ~raw[k];
                    dur[k] = pick_dur();
                end
            end
            if (c == 2000) begin
                chk_en = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_en = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
